// File: rtl/rx_block_sync_if.sv
// Receive-side bundle between the GT RX gearbox, rx_block_sync and the descrambler.
// Optional error-counter signals exist only when RX_ERR_CNT_EN is defined.
interface rx_block_sync_if #(
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0] data_i;
  logic [1:0]        head_i;
  logic              head_valid_i;
  logic              slip_o;
  logic [63:0]       block_o;
  logic [1:0]        head_o;
  logic              block_valid_o;
  logic              block_lock_o;
  logic              hi_ber_o;
`ifdef RX_ERR_CNT_EN
  logic              err_clr_i;
  logic [15:0]       err_cnt_o;

  modport master (
    output data_i, head_i, head_valid_i, err_clr_i,
    input  slip_o, block_o, head_o, block_valid_o, block_lock_o, hi_ber_o, err_cnt_o
  );
  modport slave (
    input  data_i, head_i, head_valid_i, err_clr_i,
    output slip_o, block_o, head_o, block_valid_o, block_lock_o, hi_ber_o, err_cnt_o
  );
`else
  modport master (
    output data_i, head_i, head_valid_i,
    input  slip_o, block_o, head_o, block_valid_o, block_lock_o, hi_ber_o
  );
  modport slave (
    input  data_i, head_i, head_valid_i,
    output slip_o, block_o, head_o, block_valid_o, block_lock_o, hi_ber_o
  );
`endif
endinterface

// File: rtl/rx_block_sync.sv
// 10GBASE-R receive front end: block lock, gearbox slip, hi-BER monitor, 66b assembly.
// Define RX_ERR_CNT_EN to add a saturating locked-state header error counter.
module rx_block_sync #(
  parameter int DATA_W     = 32,
  parameter int LOCK_CNT   = 64,
  parameter int WIN_LEN    = 64,
  parameter int UNLOCK_CNT = 16,
  parameter int SLIP_GAP   = 32,
  parameter int BER_WINDOW = 39062,
  parameter int BER_THRESH = 16
) (
  input  logic           clk_i,
  input  logic           rst_i,
  rx_block_sync_if.slave rx
);

  localparam int SH_W  = $clog2(LOCK_CNT + 1);
  localparam int GAP_W = $clog2(SLIP_GAP + 1);
  localparam int WIN_W = $clog2(WIN_LEN + 1);
  localparam int BAD_W = $clog2(UNLOCK_CNT + 1);
  localparam int TMR_W = $clog2(BER_WINDOW + 1);
  localparam int BER_W = $clog2(BER_THRESH + 1);

  typedef enum logic [1:0] {
    HUNT,
    SLIP_WAIT,
    LOCKED
  } state_t;

  state_t             state_q, state_d;
  logic [SH_W-1:0]    sh_cnt_q, sh_cnt_d;
  logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
  logic [WIN_W-1:0]   win_cnt_q, win_cnt_d;
  logic [BAD_W-1:0]   bad_cnt_q, bad_cnt_d;
  logic               slip_q, slip_d;
  logic               block_lock_q, block_lock_d;
  logic               unlock;

  logic [TMR_W-1:0]   ber_tmr_q;
  logic [BER_W-1:0]   ber_cnt_q, ber_cnt_nx;
  logic               ber_hit;
  logic               hi_ber_q;

  logic [63:0]        block_q;
  logic [1:0]         head_q;
  logic               asm_vld_q;

  logic head_ok, tested, bad_hdr;

  // Only 01/10 are legal sync headers; headers arriving during a slip wait are stale.
  assign head_ok = rx.head_i == 2'b01 || rx.head_i == 2'b10;
  assign tested  = rx.head_valid_i && state_q != SLIP_WAIT;
  assign bad_hdr = tested && !head_ok;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= HUNT;
      sh_cnt_q     <= '0;
      gap_cnt_q    <= '0;
      win_cnt_q    <= '0;
      bad_cnt_q    <= '0;
      slip_q       <= 1'b0;
      block_lock_q <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
      state_q      <= state_d;
      sh_cnt_q     <= sh_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      win_cnt_q    <= win_cnt_d;
      bad_cnt_q    <= bad_cnt_d;
      slip_q       <= slip_d;
      block_lock_q <= block_lock_d;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d      = state_q;
    sh_cnt_d     = sh_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    win_cnt_d    = win_cnt_q;
    bad_cnt_d    = bad_cnt_q;
    slip_d       = 1'b0;
    block_lock_d = block_lock_q;
    unlock       = 1'b0;
    unique case (state_q)
      HUNT: begin
        block_lock_d = 1'b0;
        win_cnt_d    = '0;
        bad_cnt_d    = '0;
        if (tested) begin
          if (!head_ok) begin
            slip_d    = 1'b1;
            sh_cnt_d  = '0;
            gap_cnt_d = '0;
            state_d   = SLIP_WAIT;
          end else if (sh_cnt_q == SH_W'(LOCK_CNT - 1)) begin
            sh_cnt_d     = '0;
            block_lock_d = 1'b1;
            state_d      = LOCKED;
          end else begin
            sh_cnt_d = sh_cnt_q + SH_W'(1);
          end
        end
      end
      SLIP_WAIT: begin
        if (gap_cnt_q == GAP_W'(SLIP_GAP - 1)) begin
          gap_cnt_d = '0;
          state_d   = HUNT;
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
      end
      LOCKED: begin
        if (tested) begin
          // Unlock is tested before window end so a bad header on the last slot counts in this window.
          if (!head_ok && bad_cnt_q == BAD_W'(UNLOCK_CNT - 1)) begin
            unlock       = 1'b1;
            slip_d       = 1'b1;
            block_lock_d = 1'b0;
            gap_cnt_d    = '0;
            win_cnt_d    = '0;
            bad_cnt_d    = '0;
            state_d      = SLIP_WAIT;
          end else if (win_cnt_q == WIN_W'(WIN_LEN - 1)) begin
            win_cnt_d = '0;
            bad_cnt_d = '0;
          end else begin
            win_cnt_d = win_cnt_q + WIN_W'(1);
            if (!head_ok) bad_cnt_d = bad_cnt_q + BAD_W'(1);
          end
        end
      end
      default: state_d = HUNT;
    endcase
  end

  always_comb begin
    ber_cnt_nx = ber_cnt_q;
    if (bad_hdr && ber_cnt_q != BER_W'(BER_THRESH)) ber_cnt_nx = ber_cnt_q + BER_W'(1);
  end
  assign ber_hit = ber_cnt_nx == BER_W'(BER_THRESH);

  // The BER window only runs while locked; an unlock on this edge overrides a threshold hit.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ber_tmr_q <= '0;
      ber_cnt_q <= '0;
      hi_ber_q  <= 1'b0;
    end else if (state_q != LOCKED || unlock) begin
      ber_tmr_q <= '0;
      ber_cnt_q <= '0;
      hi_ber_q  <= 1'b0;
    end else if (ber_tmr_q == TMR_W'(BER_WINDOW - 1)) begin
      ber_tmr_q <= '0;
      ber_cnt_q <= '0;
      hi_ber_q  <= ber_hit;
    end else begin
      ber_tmr_q <= ber_tmr_q + TMR_W'(1);
      ber_cnt_q <= ber_cnt_nx;
      if (ber_hit) hi_ber_q <= 1'b1;
    end
  end

  // A block is presented only if lock already held when its header arrived.
  if (DATA_W == 32) begin : g_asm32
    logic        pend_q;
    logic [31:0] lat_data_q;
    logic [1:0]  lat_head_q;
    logic        lat_lock_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        // NOTE: these are plain registers, not a memory, so resetting them all is cheap and keeps outputs defined.
        pend_q     <= 1'b0;
        lat_data_q <= '0;
        lat_head_q <= '0;
        lat_lock_q <= 1'b0;
        asm_vld_q  <= 1'b0;
        block_q    <= '0;
        head_q     <= '0;
      end else begin
        asm_vld_q <= 1'b0;
        if (rx.head_valid_i) begin
          pend_q     <= 1'b1;
          lat_data_q <= rx.data_i;
          lat_head_q <= rx.head_i;
          lat_lock_q <= block_lock_q;
        end else if (pend_q) begin
          pend_q <= 1'b0;
          if (lat_lock_q) begin
            block_q   <= {lat_data_q, rx.data_i};
            head_q    <= lat_head_q;
            asm_vld_q <= 1'b1;
          end
        end
      end
    end
  end else if (DATA_W == 64) begin : g_asm64
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        asm_vld_q <= 1'b0;
        block_q   <= '0;
        head_q    <= '0;
      end else begin
        asm_vld_q <= 1'b0;
        if (rx.head_valid_i && block_lock_q) begin
          block_q   <= rx.data_i;
          head_q    <= rx.head_i;
          asm_vld_q <= 1'b1;
        end
      end
    end
  end else begin : g_bad_width
    $error("rx_block_sync: DATA_W must be 32 or 64");
  end

`ifdef RX_ERR_CNT_EN
  logic [15:0] err_cnt_q;

  // Survives loss of lock; only reset or err_clr_i zero it, and a clear beats a same-cycle error.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                                              err_cnt_q <= '0;
    else if (rx.err_clr_i)                                  err_cnt_q <= '0;
    else if (state_q == LOCKED && bad_hdr && err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
  end
  assign rx.err_cnt_o = err_cnt_q;
`endif

  assign rx.slip_o        = slip_q;
  assign rx.block_lock_o  = block_lock_q;
  assign rx.hi_ber_o      = hi_ber_q;
  assign rx.block_o       = block_q;
  assign rx.head_o        = head_q;
  assign rx.block_valid_o = asm_vld_q && block_lock_q;

endmodule

// File: tb/tb_rx_block_sync.sv
// Self-checking bench for rx_block_sync (DATA_W=32, BER_WINDOW=100): lock, slip, unlock,
// hi-BER, 66b assembly and asynchronous reset; blocks are matched through a scoreboard queue.
module tb_rx_block_sync;
  localparam int DATA_W = 32;

  logic clk_i = 1'b0;
  logic rst_i;
  always #5 clk_i = ~clk_i;

  rx_block_sync_if #(.DATA_W(DATA_W)) rx ();

  rx_block_sync #(.DATA_W(DATA_W), .BER_WINDOW(100)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .rx    (rx)
  );

  typedef struct {
    logic [63:0] blk;
    logic [1:0]  head;
  } exp_t;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic [1:0]  head;
    logic [63:0] exp_blk;
    logic        exp_lock;
  } vec_t;

  exp_t        sb_q[$];
  int          n_pass  = 0;
  int          n_total = 0;

  // Bench-side pairing model: latest header beat pairs with the next non-header beat.
  bit          pend      = 1'b0;
  logic [31:0] pend_data = '0;
  logic [1:0]  pend_head = '0;
  bit          pend_lock = 1'b0;
  bit          exp_lock  = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic beat(input logic [31:0] d, input logic [1:0] h, input logic hv);
    rx.data_i       = d;
    rx.head_i       = h;
    rx.head_valid_i = hv;
    if (hv) begin
      pend      = 1'b1;
      pend_data = d;
      pend_head = h;
      pend_lock = exp_lock;
    end else if (pend) begin
      pend = 1'b0;
      if (pend_lock) sb_q.push_back('{blk: {pend_data, d}, head: pend_head});
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic hdr(input logic [1:0] h);
    beat($urandom, h, 1'b1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) beat($urandom, 2'b00, 1'b0);
  endtask

  always @(negedge clk_i) begin
    if (rst_i === 1'b0 && rx.block_valid_o === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_total++;
        $display("FAIL sb_unexpected: block_valid_o=1 block_o=%h, expected no block", rx.block_o);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("sb_block", rx.block_o, e.blk);
        check("sb_head", 64'(rx.head_o), 64'(e.head));
      end
    end
  end

  initial begin
    vec_t vecs[6];
    int   slips;
    int   drops;

    vecs[0] = '{32'hAAAA0001, 32'h5555FFFF, 2'b10, 64'hAAAA00015555FFFF, 1'b1};
    vecs[1] = '{32'h12345678, 32'h9ABCDEF0, 2'b01, 64'h123456789ABCDEF0, 1'b1};
    vecs[2] = '{32'hDEADBEEF, 32'h00000000, 2'b11, 64'hDEADBEEF00000000, 1'b1};
    vecs[3] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 2'b01, 64'hFFFFFFFFFFFFFFFF, 1'b1};
    vecs[4] = '{32'h00000000, 32'h00000001, 2'b00, 64'h0000000000000001, 1'b1};
    vecs[5] = '{32'hCAFEF00D, 32'h0BADC0DE, 2'b10, 64'hCAFEF00D0BADC0DE, 1'b1};

    rst_i           = 1'b1;
    rx.data_i       = '0;
    rx.head_i       = '0;
    rx.head_valid_i = 1'b0;
`ifdef RX_ERR_CNT_EN
    rx.err_clr_i    = 1'b0;
`endif
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_slip",  64'(rx.slip_o), 64'd0);
    check("rst_lock",  64'(rx.block_lock_o), 64'd0);
    check("rst_hiber", 64'(rx.hi_ber_o), 64'd0);
    check("rst_valid", 64'(rx.block_valid_o), 64'd0);
    check("rst_block", rx.block_o, 64'd0);
    check("rst_head",  64'(rx.head_o), 64'd0);
    rst_i = 1'b0;

    // Hunt slip: one pulse, then 32 quiet cycles even with bad headers.
    for (int i = 0; i < 5; i++) hdr(2'b01);
    hdr(2'b00);
    check("hunt_slip", 64'(rx.slip_o), 64'd1);
    slips = 0;
    for (int i = 0; i < 31; i++) begin
      hdr(2'b00);
      slips += int'(rx.slip_o);
    end
    check("slip_gap_quiet", 64'(slips), 64'd0);
    hdr(2'b00);
    check("slip_gap_last", 64'(rx.slip_o), 64'd0);
    hdr(2'b00);
    check("slip_after_gap", 64'(rx.slip_o), 64'd1);
    idle(40);

    // Lock acquisition.
    for (int i = 0; i < 63; i++) hdr(2'b01);
    check("lock_at_63", 64'(rx.block_lock_o), 64'd0);
    hdr(2'b10);
    check("lock_at_64", 64'(rx.block_lock_o), 64'd1);
    exp_lock = 1'b1;

    // Table-driven block assembly while locked (two bad headers among them).
    for (int i = 0; i < 6; i++) begin
      beat(vecs[i].hi, vecs[i].head, 1'b1);
      beat(vecs[i].lo, 2'b00, 1'b0);
      check("vec_block", rx.block_o, vecs[i].exp_blk);
      check("vec_head",  64'(rx.head_o), 64'(vecs[i].head));
      check("vec_valid", 64'(rx.block_valid_o), 64'd1);
      check("vec_lock",  64'(rx.block_lock_o), 64'(vecs[i].exp_lock));
    end
    idle(1);
    check("valid_one_cycle", 64'(rx.block_valid_o), 64'd0);

    // Close the first window, then 15 bad per window for 3 windows.
    for (int i = 0; i < 58; i++) hdr(2'b01);
    slips = 0;
    drops = 0;
    for (int w = 0; w < 3; w++) begin
      for (int i = 0; i < 64; i++) begin
        if (w == 0) hdr(i >= 49 ? 2'b11 : 2'b01);
        else        hdr(i < 15  ? 2'b00 : 2'b10);
        slips += int'(rx.slip_o);
        drops += int'(!rx.block_lock_o);
      end
    end
    check("win15_slips", 64'(slips), 64'd0);
    check("win15_drops", 64'(drops), 64'd0);

    // Unlock on the 16th bad header of a window.
    for (int i = 0; i < 10; i++) hdr(2'b01);
    for (int i = 0; i < 15; i++) hdr(2'b11);
    check("unlock_at_15", 64'(rx.block_lock_o), 64'd1);
    hdr(2'b11);
    check("unlock_lock",  64'(rx.block_lock_o), 64'd0);
    check("unlock_slip",  64'(rx.slip_o), 64'd1);
    check("unlock_hiber", 64'(rx.hi_ber_o), 64'd0);
    exp_lock  = 1'b0;
    pend_lock = 1'b0;
    idle(1);
    check("unlock_slip_end", 64'(rx.slip_o), 64'd0);
`ifdef RX_ERR_CNT_EN
    check("err_cnt_total", 64'(rx.err_cnt_o), 64'd63);
`endif
    idle(40);

    // Relock, then hi-BER: 8 bad at the end of one lock window, 8 at the start of the next.
    for (int i = 0; i < 64; i++) hdr(2'b01);
    check("relock", 64'(rx.block_lock_o), 64'd1);
    exp_lock = 1'b1;
    for (int n = 0; n < 200; n++) begin
      hdr((n >= 56 && n < 72) ? 2'b11 : 2'b01);
      if (n == 70)  check("hiber_at_15",    64'(rx.hi_ber_o), 64'd0);
      if (n == 71)  check("hiber_at_16",    64'(rx.hi_ber_o), 64'd1);
      if (n == 99)  check("hiber_hold_exp", 64'(rx.hi_ber_o), 64'd1);
      if (n == 198) check("hiber_pre_clr",  64'(rx.hi_ber_o), 64'd1);
      if (n == 199) check("hiber_clr",      64'(rx.hi_ber_o), 64'd0);
    end
    check("hiber_lock", 64'(rx.block_lock_o), 64'd1);

    // Asynchronous reset mid-window.
    beat(32'h01234567, 2'b01, 1'b1);
    beat(32'h89ABCDEF, 2'b00, 1'b0);
    idle(1);
    check("pre_rst_block", rx.block_o, 64'h0123456789ABCDEF);
    #2;
    rst_i = 1'b1;
    #1;
    check("arst_lock",  64'(rx.block_lock_o), 64'd0);
    check("arst_block", rx.block_o, 64'd0);
    check("arst_head",  64'(rx.head_o), 64'd0);
    check("arst_slip",  64'(rx.slip_o), 64'd0);
    check("arst_hiber", 64'(rx.hi_ber_o), 64'd0);
    exp_lock  = 1'b0;
    pend      = 1'b0;
    pend_lock = 1'b0;
    sb_q.delete();
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    for (int i = 0; i < 63; i++) hdr(2'b01);
    check("rst_relock_63", 64'(rx.block_lock_o), 64'd0);
    hdr(2'b01);
    check("rst_relock_64", 64'(rx.block_lock_o), 64'd1);
    exp_lock = 1'b1;
`ifdef RX_ERR_CNT_EN
    hdr(2'b11);
    hdr(2'b00);
    check("err_cnt_two", 64'(rx.err_cnt_o), 64'd2);
    rx.err_clr_i = 1'b1;
    hdr(2'b11);
    rx.err_clr_i = 1'b0;
    check("err_clr_wins", 64'(rx.err_cnt_o), 64'd0);
`endif
    idle(2);
    check("sb_drain", 64'(sb_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
